// File: rtl/apb_uart_rx_pkg.sv
// Shared definitions for the APB UART receiver: register word addresses,
// CTRL/STATUS bit positions, receive FSM encoding and a parity helper.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

  localparam logic [9:0] ADDR_RXDATA  = 10'd0;
  localparam logic [9:0] ADDR_STATUS  = 10'd1;
  localparam logic [9:0] ADDR_CTRL    = 10'd2;
  localparam logic [9:0] ADDR_BAUDDIV = 10'd4;

  localparam int CTRL_RXEN   = 1;
  localparam int CTRL_RXIE   = 2;
  localparam int CTRL_PAREN  = 3;
  localparam int CTRL_PARODD = 4;
  localparam int CTRL_OVRIE  = 5;

  localparam int ST_RXNE = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;
  localparam int ST_PERR = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } rx_state_e;

  // High when the received parity bit does not match the configured sense
  // (odd = 0 -> even parity over data plus parity bit).
  function automatic logic calc_parity_err(input logic [7:0] data,
                                           input logic       par_bit,
                                           input logic       odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/apb_uart_rx_fifo.sv
// Synchronous receive FIFO, DEPTH x WIDTH. Pointers carry one extra wrap
// bit so full and empty are distinguished without a counter. A push while
// full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and pushes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; cleared on reset so the head word is never X.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/apb_uart_rx.sv
// APB slave UART receiver (8N1, optional parity with UART_RX_PARITY_EN).
// RXD is double-synchronised, frames are sampled mid-bit using a BAUDDIV
// down-counter, and received bytes land in a small FIFO read via RXDATA.
module apb_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_MIN    = 16
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        PSEL,
  input  logic [11:2] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        RXD,
  output logic        RXINT
);

`ifdef UART_RX_PARITY_EN
  localparam logic [5:0] CTRL_WMASK = 6'b111110;
`else
  localparam logic [5:0] CTRL_WMASK = 6'b100110;
`endif

  rx_state_e   r_state;
  rx_state_e   w_state_nxt;
  logic [5:0]  r_ctrl;
  logic [15:0] r_bauddiv;
  logic [15:0] r_baud_cnt;
  logic [15:0] w_baud_nxt;
  logic [3:0]  r_bit_cnt;
  logic [3:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_par_err;
  logic        w_par_err_nxt;
  logic        r_rxd_meta;
  logic        r_rxd_sync;
  logic        r_rxd_prev;
  logic        r_ovr;
  logic        r_ferr;
  logic        r_perr;
  logic        r_rxint;
  logic        w_fall;
  logic        w_rx_enabled;
  logic        w_tick;
  logic [15:0] w_reload;
  logic        w_stop_ok;
  logic        w_ferr_set;
  logic        w_perr_set;
  logic        w_ovr_set;
  logic        w_wr;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_fifo_dout;
  logic [31:0] w_prdata;
  logic [2:0]  w_clr;
  logic        w_unused_ok;

  assign PREADY       = 1'b1;
  assign PRDATA       = w_prdata;
  assign RXINT        = r_rxint;
  assign w_unused_ok  = &{1'b0, PWDATA[31:16]};
  assign w_fall       = r_rxd_prev & ~r_rxd_sync;
  assign w_rx_enabled = r_ctrl[CTRL_RXEN] & (r_bauddiv >= 16'(DIV_MIN));
  assign w_tick       = (r_baud_cnt == 16'd0);
  assign w_reload     = r_bauddiv - 16'd1;
  assign w_wr         = PSEL & PENABLE & PWRITE;
  assign w_pop        = PSEL & PENABLE & ~PWRITE & (PADDR == ADDR_RXDATA) & ~w_empty;
  assign w_ovr_set    = w_stop_ok & w_full & ~w_pop;
  assign w_clr        = (w_wr && (PADDR == ADDR_STATUS)) ? PWDATA[4:2] : 3'b000;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  // Software-visible CTRL and BAUDDIV registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ctrl    <= 6'd0;
      r_bauddiv <= 16'd0;
    end else if (w_wr) begin
      if (PADDR == ADDR_CTRL) begin
        r_ctrl <= PWDATA[5:0] & CTRL_WMASK;
      end else if (PADDR == ADDR_BAUDDIV) begin
        r_bauddiv <= PWDATA[15:0];
      end else begin
        r_ctrl <= r_ctrl;
      end
    end else begin
      r_ctrl <= r_ctrl;
    end
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_par_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par_err  <= w_par_err_nxt;
    end
  end

  // Next-state logic: counter reloads at each sample point, abort on disable.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud_cnt - 16'd1;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_err_nxt = r_par_err;
    w_stop_ok     = 1'b0;
    w_ferr_set    = 1'b0;
    w_perr_set    = 1'b0;
    if ((r_state != S_IDLE) && !w_rx_enabled) begin
      w_state_nxt = S_IDLE;
      w_baud_nxt  = 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_bit_nxt     = 4'd0;
          w_par_err_nxt = 1'b0;
          if (w_rx_enabled && w_fall) begin
            w_state_nxt = S_START;
            w_baud_nxt  = (r_bauddiv >> 1) - 16'd1;
          end else begin
            w_baud_nxt  = 16'd0;
          end
        end
        S_START: begin
          if (w_tick) begin
            w_baud_nxt = w_reload;
            // A high line at mid-start is a glitch; drop back silently.
            if (!r_rxd_sync) begin
              w_state_nxt = S_DATA;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_START;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            w_baud_nxt  = w_reload;
            w_shift_nxt = {r_rxd_sync, r_shift[7:1]};
            if (r_bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              if (r_ctrl[CTRL_PAREN]) begin
                w_state_nxt = S_PARITY;
              end else begin
                w_state_nxt = S_STOP;
              end
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit_cnt + 4'd1;
            end
          end else begin
            w_state_nxt = S_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            w_baud_nxt  = w_reload;
            w_state_nxt = S_STOP;
            if (calc_parity_err(r_shift, r_rxd_sync, r_ctrl[CTRL_PARODD])) begin
              w_par_err_nxt = 1'b1;
              w_perr_set    = 1'b1;
            end else begin
              w_par_err_nxt = 1'b0;
            end
          end else begin
            w_state_nxt = S_PARITY;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            w_state_nxt = S_IDLE;
            if (r_rxd_sync) begin
              w_stop_ok = ~r_par_err;
            end else begin
              w_ferr_set = 1'b1;
            end
          end else begin
            w_state_nxt = S_STOP;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = 16'd0;
        end
      endcase
    end
  end

  // Sticky error flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set  | (r_ovr  & ~w_clr[0]);
      r_ferr <= w_ferr_set | (r_ferr & ~w_clr[1]);
      r_perr <= w_perr_set | (r_perr & ~w_clr[2]);
    end
  end

  // Interrupt request registered from the current flag values.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rxint <= 1'b0;
    end else begin
      r_rxint <= (r_ctrl[CTRL_RXIE] & ~w_empty) | (r_ctrl[CTRL_OVRIE] & r_ovr);
    end
  end

  // APB read mux; empty RXDATA reads return zero.
  always_comb begin
    w_prdata = 32'd0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        ADDR_RXDATA: begin
          if (!w_empty) begin
            w_prdata = {24'd0, w_fifo_dout};
          end else begin
            w_prdata = 32'd0;
          end
        end
        ADDR_STATUS:  w_prdata = {27'd0, r_perr, r_ferr, r_ovr, w_full, ~w_empty};
        ADDR_CTRL:    w_prdata = {26'd0, r_ctrl};
        ADDR_BAUDDIV: w_prdata = {16'd0, r_bauddiv};
        default:      w_prdata = 32'd0;
      endcase
    end else begin
      w_prdata = 32'd0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESETn),
    .i_push  (w_stop_ok),
    .i_pop   (w_pop),
    .i_din   (r_shift),
    .o_dout  (w_fifo_dout),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: doc/apb_uart_rx.md
Name: apb_uart_rx

Overview:
- APB slave UART receiver; the peripheral driven by the APB test sequencers in the UART test group.
- Samples the serial RXD line and deserialises 8N1 frames into a small RX FIFO.
- Exposes data, status, control and baud-divisor registers to a zero-wait APB master.
- Raises RXINT on data-available or overrun.

Parameters:
- FIFO_DEPTH, 4, RX FIFO entries; power of 2, minimum 2.
- DIV_MIN, 16, smallest legal BAUDDIV; any lower value holds the receiver idle.

Ports:
- CLK  in  1  clock
- RESETn  in  1  asynchronous active-low reset
- PSEL  in  1  APB device select
- PADDR  in  [11:2]  APB word address
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write control
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data; combinational, valid when PSEL & ~PWRITE
- PREADY  out  1  tied to 1; no wait states
- RXD  in  1  asynchronous serial input, idle high
- RXINT  out  1  registered interrupt request

Behaviour:
- Register map (PADDR word index):
  - 0 RXDATA (RO): [7:0] head byte; reading it pops the FIFO. Returns 0x0000_0000 when empty, with no pop.
  - 1 STATUS: bit0 RXNE, bit1 FULL (RO); bit2 OVR, bit3 FERR, bit4 PERR (W1C).
  - 2 CTRL (RW): bit1 RXEN, bit2 RXIE, bit5 OVRIE; other bits read 0.
  - 4 BAUDDIV (RW): [15:0] CLK cycles per bit.
  - Other addresses read 0; writes to them are ignored.
- APB write commits on PSEL & PENABLE & PWRITE. RXDATA pop happens on PSEL & PENABLE & ~PWRITE & PADDR==0 & ~empty.
- Reset values: CTRL=0, BAUDDIV=0, STATUS flags 0, FIFO empty, RXINT=0, synchroniser flops=1, FSM=IDLE.
- RXD passes through a 2-flop synchroniser before any use.
- FSM states and transitions:
  - IDLE → START on a synchronised falling edge, only when RXEN=1 and BAUDDIV>=DIV_MIN.
  - START: wait BAUDDIV>>1 cycles, then sample. Low → DATA. High → IDLE (glitch rejected, no flag).
  - DATA: 8 samples, each BAUDDIV cycles apart, shifted in LSB first. → PARITY (feature on and enabled) or STOP.
  - STOP: sample after BAUDDIV cycles.
    - High: push the byte; if FIFO full, drop it and set OVR.
    - Low: set FERR and discard the byte.
    - Either case → IDLE. Line must return high before the next start is recognised.
- Bit counter: 4 bits. Baud counter: 16 bits, reloaded at each sample point.
- Clearing RXEN mid-frame: FSM returns to IDLE next cycle; partial byte is discarded; FIFO contents are kept.
- BAUDDIV written mid-frame: takes effect at the next counter reload.
- Push and pop in the same cycle: both occur, count unchanged. This is legal even when full; no OVR in that case.
- Flag set and W1C clear in the same cycle: set wins.
- RXINT <= (RXIE & RXNE) | (OVRIE & OVR), registered, so 1-cycle latency from the flag change.
- Latency: stop-bit sample to RXNE=1 is 1 cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - CTRL bit3 PAREN and bit4 PARODD become RW.
  - When PAREN=1, one parity bit is sampled after the data bits.
  - On mismatch: set PERR, drop the byte, still check the stop bit.
- Undefined:
  - CTRL bits 3/4 read 0.
  - STATUS bit4 reads 0.
  - No PARITY state exists.

Decomposition:
- Package uart_rx_pkg holds:
  - Register word addresses: RXDATA=0, STATUS=1, CTRL=2, BAUDDIV=4.
  - CTRL and STATUS bit positions.
  - FSM state encoding typedef: IDLE, START, DATA, PARITY, STOP.
- Sub-module uart_rx_fifo:
  - Synchronous FIFO, FIFO_DEPTH x 8.
  - Ports: push, pop, din, dout, empty, full.
  - Pointers carry one extra wrap bit.

Test Plan:
- Nominal frame: write BAUDDIV=0x20, CTRL=0x26; drive frame 0x53 (32 cycles/bit). → STATUS=0x1 about 320 cycles later; RXDATA read returns 0x53; STATUS then reads 0x0; RXINT asserts and then deasserts.
- Empty poll: read RXDATA with FIFO empty → 0x0000_0000; STATUS unchanged; no pointer movement.
- Overrun: send 5 frames (0x01..0x05) with no reads. → FULL=1 and OVR=1, RXINT=1. Reads return 0x01..0x04, then 0. Writing STATUS=0x4 clears OVR.
- Framing error: send 0xA5 with stop bit low. → FERR=1, RXNE=0.
- Glitch rejection: low pulse of 8 cycles at BAUDDIV=0x20 → FSM returns to IDLE; no flags; no data.
- Parity (UART_RX_PARITY_EN defined): CTRL=0x2E (even parity); send 0x53 with parity=1 (wrong) → PERR=1, no data. Send with correct parity=0 → 0x53 received.
